// File: rtl/router_pkg.sv
// Shared router constants: flit/address widths, header length, and the
// state encoding of the input-port flit buffer.
package router_pkg;

    localparam int INPUT_SIZE   = 4;
    localparam int ADDRESS_SIZE = 16;

    // Number of header flits needed to carry one full address.
    function automatic int flits_per_address(input int addr_bits, input int flit_bits);
        return addr_bits / flit_bits;
    endfunction

    localparam int ADDRESS_FLIT_NUMBER = flits_per_address(ADDRESS_SIZE, INPUT_SIZE);

    // Input-port FSM encoding (3-bit, kept stable for existing checkers).
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_HDR  = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_PAY  = 3'd4;

endpackage

// File: rtl/flit_fifo.sv
// Circular flit FIFO. The head is read straight from storage, so a pushed
// flit becomes visible no earlier than the cycle after its push.
module flit_fifo #(
    parameter int input_size = 4,
    parameter int fifo_depth = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  logic                              pop,
    input  logic [input_size-1:0]             din,
    output logic [input_size-1:0]             dout,
    output logic [$clog2(fifo_depth+1)-1:0]   count,
    output logic                              full,
    output logic                              empty
);

    localparam int PW = $clog2(fifo_depth);
    localparam int CW = $clog2(fifo_depth + 1);

    logic [input_size-1:0] mem [fifo_depth];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  do_push;
    logic                  do_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count_q == CW'(fifo_depth));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem[rd_ptr];

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally (depth is a power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_q + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/input_port_flit_buffer.sv
// Router input port: buffers link flits, hands the header to the routing
// controller one flit per shift strobe, then streams a fixed-length payload
// to the crossbar.
//
// Handshakes: a link flit transfers on a cycle with in_valid && in_ready; a
// payload flit transfers on a cycle with payload_valid && payload_ready.
// valid never depends on ready, and a presented flit stays stable until it
// transfers. Header flits transfer on every HDR cycle with
// shift_current_address while the FIFO holds data.
module input_port_flit_buffer
    import router_pkg::*;
#(
    parameter int input_size    = INPUT_SIZE,
    parameter int address_size  = ADDRESS_SIZE,
    parameter int fifo_depth    = 8,
    parameter int payload_flits = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [input_size-1:0]             in_flit,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              compute_address,
    input  logic                              shift_current_address,
    output logic [input_size-1:0]             addr_flit,
    input  logic                              send_finish,
    output logic [input_size-1:0]             payload_flit,
    output logic                              payload_valid,
    input  logic                              payload_ready,
    output logic                              busy,
    output logic [$clog2(fifo_depth+1)-1:0]   fifo_count,
    output logic                              proto_err
);

    localparam int CW  = $clog2(fifo_depth + 1);
    localparam int AFN = flits_per_address(address_size, input_size);
    localparam int PCW = $clog2(payload_flits + 1);

    localparam logic [CW-1:0]  HDR_NEED = CW'(AFN);
    localparam logic [CW-1:0]  HDR_LAST = CW'(AFN - 1);
    localparam logic [PCW-1:0] PAY_LAST = PCW'(payload_flits - 1);

    logic [2:0]            state;
    logic [CW-1:0]         hdr_cnt;
    logic [PCW-1:0]        pay_cnt;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [input_size-1:0] fifo_head;
    logic                  proto_set;

    // in_ready is held low while reset is asserted and recovers as soon as
    // reset drops, since the FIFO is already empty by then.
    assign in_ready  = !fifo_full && !reset;
    assign fifo_push = in_valid && in_ready;

    flit_fifo #(
        .input_size (input_size),
        .fifo_depth (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (in_flit),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Each head view is qualified only by its own state.
    assign compute_address = (state == ST_REQ);
    assign busy            = (state != ST_IDLE);
    assign payload_valid   = (state == ST_PAY) && !fifo_empty;
    assign addr_flit       = (state == ST_HDR) ? fifo_head : '0;
    assign payload_flit    = payload_valid ? fifo_head : '0;

    // Pop decision and protocol-error detection for the current state.
    always_comb begin
        fifo_pop  = 1'b0;
        proto_set = 1'b0;
        case (state)
            ST_HDR: begin
                if (shift_current_address) begin
                    if (fifo_empty) begin
                        proto_set = 1'b1;
                    end else begin
                        fifo_pop = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (shift_current_address) begin
                    proto_set = 1'b1;
                end
            end
            ST_PAY: begin
                fifo_pop = payload_valid && payload_ready;
            end
            default: begin
                fifo_pop  = 1'b0;
                proto_set = 1'b0;
            end
        endcase
    end

    // Packet-framing FSM with header/payload counters and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            hdr_cnt   <= '0;
            pay_cnt   <= '0;
            proto_err <= 1'b0;
        end else begin
            if (proto_set) begin
                proto_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    // Whole header buffered before the controller starts shifting.
                    if (fifo_count >= HDR_NEED) begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    state <= ST_HDR;
                end
                ST_HDR: begin
                    if (fifo_pop) begin
                        if (hdr_cnt == HDR_LAST) begin
                            hdr_cnt <= '0;
                            state   <= ST_WAIT;
                        end else begin
                            hdr_cnt <= hdr_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (send_finish) begin
                        state <= ST_PAY;
                    end
                end
                ST_PAY: begin
                    if (fifo_pop) begin
                        if (pay_cnt == PAY_LAST) begin
                            pay_cnt <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            pay_cnt <= pay_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_port_flit_buffer.sv
// Bench for input_port_flit_buffer: a cycle table for one packet, then
// hand-written sequences for threshold, full FIFO, backpressure, reset and
// protocol-error corner cases.
module tb_input_port_flit_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_flit;
    logic       in_valid;
    logic       in_ready;
    logic       compute_address;
    logic       shift_current_address;
    logic [3:0] addr_flit;
    logic       send_finish;
    logic [3:0] payload_flit;
    logic       payload_valid;
    logic       payload_ready;
    logic       busy;
    logic [3:0] fifo_count;
    logic       proto_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] exp_q[$];
    logic [3:0] link_q[$];

    typedef struct {
        logic       in_valid;
        logic [3:0] in_flit;
        logic       shift;
        logic       fin;
        logic       pready;
        logic       e_in_ready;
        logic       e_comp;
        logic [3:0] e_addr;
        logic       e_pv;
        logic [3:0] e_pf;
        logic       e_busy;
        logic [3:0] e_count;
    } vec_t;

    vec_t tbl[17];

    // Clock
    always #5 clk = ~clk;

    input_port_flit_buffer dut (
        .clk                   (clk),
        .reset                 (reset),
        .in_flit               (in_flit),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .compute_address       (compute_address),
        .shift_current_address (shift_current_address),
        .addr_flit             (addr_flit),
        .send_finish           (send_finish),
        .payload_flit          (payload_flit),
        .payload_valid         (payload_valid),
        .payload_ready         (payload_ready),
        .busy                  (busy),
        .fifo_count            (fifo_count),
        .proto_err             (proto_err)
    );

    function automatic vec_t mk(input logic v, input logic [3:0] f, input logic s,
                                input logic fin, input logic pr, input logic eir,
                                input logic ec, input logic [3:0] ea, input logic epv,
                                input logic [3:0] epf, input logic eb, input logic [3:0] ecnt);
        vec_t r;
        r.in_valid = v;   r.in_flit = f;    r.shift = s;  r.fin = fin; r.pready = pr;
        r.e_in_ready = eir; r.e_comp = ec;  r.e_addr = ea; r.e_pv = epv;
        r.e_pf = epf;     r.e_busy = eb;    r.e_count = ecnt;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard: every popped flit must match the oldest accepted flit.
    task automatic expect_head(input string name, input logic [3:0] act);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: got %0h expected nothing (queue empty, t=%0t)", name, act, $time);
        end else begin
            e = exp_q.pop_front();
            check4(name, act, e);
        end
    endtask

    // Link driver: hold the flit until in_ready, record it when accepted.
    task automatic push_flit(input logic [3:0] f);
        int b;
        b = 0;
        in_valid = 1'b1;
        in_flit  = f;
        while (!in_ready && b < 60) begin
            tick();
            b++;
        end
        if (in_ready) exp_q.push_back(f);
        else check1("push_timeout", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic link_run();
        while (link_q.size() > 0) push_flit(link_q.pop_front());
    endtask

    // Routing-controller / crossbar driver for one packet.
    task automatic ctrl_packet(input bit wait_full, input logic [3:0] ready_pat,
                               input int abort_after, input bit err_in_wait);
        int b;
        int n;
        int ci;
        b = 0;
        while (!compute_address && b < 200) begin
            tick();
            b++;
        end
        check1("req_seen", compute_address, 1'b1);
        check1("req_busy", busy, 1'b1);
        tick();
        check1("req_one_cycle", compute_address, 1'b0);
        for (int i = 0; i < 4; i++) begin
            shift_current_address = 1'b1;
            expect_head("addr_flit", addr_flit);
            tick();
        end
        shift_current_address = 1'b0;
        check1("wait_no_valid", payload_valid, 1'b0);
        check1("wait_busy", busy, 1'b1);
        if (err_in_wait) begin
            shift_current_address = 1'b1;
            tick();
            shift_current_address = 1'b0;
            check1("proto_err_set", proto_err, 1'b1);
            check4("proto_count_kept", fifo_count, 4'd4);
            check1("proto_still_wait", payload_valid, 1'b0);
        end
        if (wait_full) begin
            b = 0;
            while (fifo_count != 4'd8 && b < 100) begin
                tick();
                b++;
            end
            check4("full_count", fifo_count, 4'd8);
            for (int i = 0; i < 3; i++) begin
                check1("full_in_ready", in_ready, 1'b0);
                tick();
                check4("full_hold", fifo_count, 4'd8);
            end
        end
        send_finish = 1'b1;
        tick();
        send_finish = 1'b0;
        n = 0;
        ci = 0;
        b = 0;
        while (n < 4 && b < 100 && n != abort_after) begin
            payload_ready = ready_pat[ci % 4];
            ci++;
            if (payload_valid && payload_ready) begin
                expect_head("payload_flit", payload_flit);
                n++;
            end
            tick();
            b++;
        end
        payload_ready = 1'b0;
        if (abort_after < 0) begin
            check_int("payload_count", n, 4);
            check1("idle_after_packet", busy, 1'b0);
        end
    endtask

    task automatic check_drained(input string name);
        check4({name, "_count"}, fifo_count, 4'd0);
        check_int({name, "_queue"}, exp_q.size(), 0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in_flit = '0;
        in_valid = 1'b0;
        shift_current_address = 1'b0;
        send_finish = 1'b0;
        payload_ready = 1'b0;

        //          v  flit  sh fin pr | ir cmp addr pv  pf  bsy cnt
        tbl[0]  = mk(1, 4'hA, 0, 0, 1,   1, 0, 4'h0, 0, 4'h0, 0, 4'd0);
        tbl[1]  = mk(1, 4'hB, 0, 0, 1,   1, 0, 4'h0, 0, 4'h0, 0, 4'd1);
        tbl[2]  = mk(1, 4'hC, 0, 0, 1,   1, 0, 4'h0, 0, 4'h0, 0, 4'd2);
        tbl[3]  = mk(1, 4'hD, 0, 0, 1,   1, 0, 4'h0, 0, 4'h0, 0, 4'd3);
        tbl[4]  = mk(1, 4'h1, 0, 0, 1,   1, 0, 4'h0, 0, 4'h0, 0, 4'd4);
        tbl[5]  = mk(1, 4'h2, 0, 0, 1,   1, 1, 4'h0, 0, 4'h0, 1, 4'd5);
        tbl[6]  = mk(1, 4'h3, 1, 0, 1,   1, 0, 4'hA, 0, 4'h0, 1, 4'd6);
        tbl[7]  = mk(1, 4'h4, 1, 0, 1,   1, 0, 4'hB, 0, 4'h0, 1, 4'd6);
        tbl[8]  = mk(0, 4'h0, 1, 0, 1,   1, 0, 4'hC, 0, 4'h0, 1, 4'd6);
        tbl[9]  = mk(0, 4'h0, 1, 0, 1,   1, 0, 4'hD, 0, 4'h0, 1, 4'd5);
        tbl[10] = mk(0, 4'h0, 0, 1, 1,   1, 0, 4'h0, 0, 4'h0, 1, 4'd4);
        tbl[11] = mk(0, 4'h0, 0, 0, 1,   1, 0, 4'h0, 1, 4'h1, 1, 4'd4);
        tbl[12] = mk(0, 4'h0, 0, 0, 1,   1, 0, 4'h0, 1, 4'h2, 1, 4'd3);
        tbl[13] = mk(0, 4'h0, 0, 0, 1,   1, 0, 4'h0, 1, 4'h3, 1, 4'd2);
        tbl[14] = mk(0, 4'h0, 0, 0, 1,   1, 0, 4'h0, 1, 4'h4, 1, 4'd1);
        tbl[15] = mk(0, 4'h0, 0, 0, 1,   1, 0, 4'h0, 0, 4'h0, 0, 4'd0);
        tbl[16] = mk(0, 4'h0, 0, 0, 1,   1, 0, 4'h0, 0, 4'h0, 0, 4'd0);

        // Reset state
        tick();
        tick();
        check1("rst_in_ready", in_ready, 1'b0);
        check4("rst_count", fifo_count, 4'd0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_comp", compute_address, 1'b0);
        check1("rst_pv", payload_valid, 1'b0);
        check1("rst_proto_err", proto_err, 1'b0);
        reset = 1'b0;
        #1;
        check1("rst_release_in_ready", in_ready, 1'b1);

        // Single packet, cycle by cycle
        for (int i = 0; i < 17; i++) begin
            in_valid = tbl[i].in_valid;
            in_flit = tbl[i].in_flit;
            shift_current_address = tbl[i].shift;
            send_finish = tbl[i].fin;
            payload_ready = tbl[i].pready;
            #1;
            check1($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_in_ready);
            check1($sformatf("tbl%0d_comp", i), compute_address, tbl[i].e_comp);
            check4($sformatf("tbl%0d_addr", i), addr_flit, tbl[i].e_addr);
            check1($sformatf("tbl%0d_pv", i), payload_valid, tbl[i].e_pv);
            check4($sformatf("tbl%0d_pf", i), payload_flit, tbl[i].e_pf);
            check1($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            check4($sformatf("tbl%0d_count", i), fifo_count, tbl[i].e_count);
            tick();
        end
        in_valid = 1'b0;
        shift_current_address = 1'b0;
        send_finish = 1'b0;
        payload_ready = 1'b0;

        // Header threshold: three flits are not enough to start
        push_flit(4'h3);
        push_flit(4'h5);
        push_flit(4'h7);
        for (int i = 0; i < 10; i++) begin
            check1("thr_stall_comp", compute_address, 1'b0);
            check4("thr_stall_count", fifo_count, 4'd3);
            tick();
        end
        in_valid = 1'b1;
        in_flit = 4'h9;
        check1("thr_push_comp", compute_address, 1'b0);
        exp_q.push_back(4'h9);
        tick();
        in_valid = 1'b0;
        check4("thr_visible_count", fifo_count, 4'd4);
        check1("thr_visible_no_req", compute_address, 1'b0);
        tick();
        check1("thr_req", compute_address, 1'b1);
        link_q = '{4'h1, 4'h2, 4'h4, 4'h8};
        fork
            link_run();
            ctrl_packet(1'b0, 4'b1111, -1, 1'b0);
        join
        check_drained("thr_drain");

        // Payload backpressure: ready pattern 1,0,0,1
        link_q = '{4'hE, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9};
        fork
            link_run();
            ctrl_packet(1'b0, 4'b1001, -1, 1'b0);
        join
        check_drained("bp_drain");

        // FIFO full while the controller holds send_finish low
        for (int i = 0; i < 16; i++) link_q.push_back(4'(i ^ 5));
        fork
            link_run();
            begin
                ctrl_packet(1'b1, 4'b1111, -1, 1'b0);
                ctrl_packet(1'b0, 4'b1111, -1, 1'b0);
            end
        join
        check_drained("full_drain");

        // Reset after the second payload pop
        link_q = '{4'hF, 4'hE, 4'hD, 4'hC, 4'h5, 4'h6, 4'h7, 4'h8};
        fork
            link_run();
            ctrl_packet(1'b0, 4'b1111, 2, 1'b0);
        join
        reset = 1'b1;
        exp_q.delete();
        tick();
        check4("midrst_count", fifo_count, 4'd0);
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_pv", payload_valid, 1'b0);
        check1("midrst_in_ready", in_ready, 1'b0);
        reset = 1'b0;
        #1;
        check1("midrst_release_in_ready", in_ready, 1'b1);
        link_q = '{4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE, 4'h0};
        fork
            link_run();
            ctrl_packet(1'b0, 4'b1111, -1, 1'b0);
        join
        check_drained("midrst_drain");

        // Protocol error: shift strobe during WAIT
        check1("proto_clear_before", proto_err, 1'b0);
        link_q = '{4'h1, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD, 4'hF};
        fork
            link_run();
            ctrl_packet(1'b0, 4'b1111, -1, 1'b1);
        join
        check_drained("proto_drain");
        tick();
        check1("proto_sticky", proto_err, 1'b1);
        reset = 1'b1;
        tick();
        check1("proto_cleared_by_reset", proto_err, 1'b0);
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
